x_mem_seq: RTL and testbench

Execute-stage memory access sequencer. Takes the load/store op latched in the execute stage and drives the data-memory request/grant port. Double-word ops are split into two sequential word accesses. It produces x_stall_d_o, which the hazard detection unit uses to freeze decode and PC during a second access or an ungranted access. Read data is assembled and handed to writeback.

---
 rtl/x_mem_pkg.sv | 45 ++++
 rtl/x_mem_rsp.sv | 50 +++++
 rtl/x_mem_seq.sv | 171 +++++++++++++++++
 tb/tb_x_mem_seq.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/x_mem_pkg.sv
// Shared types and op-decode helpers for the execute-stage memory sequencer.
package x_mem_pkg;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_LW   = 3'd1,
        OP_SW   = 3'd2,
        OP_LDW  = 3'd3,
        OP_SDW  = 3'd4
    } mem_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND0 = 2'd1,
        ST_PEND1 = 2'd2
    } state_t;

    // Per-read bookkeeping carried from the grant cycle to the rvalid cycle.
    typedef struct packed {
        logic       valid;
        logic       half;
        logic       last;
        logic       dbl;
        logic [4:0] rd;
    } rd_tag_t;

    function automatic mem_op_t decode_op(input logic [2:0] raw);
        case (raw)
            3'd1:    return OP_LW;
            3'd2:    return OP_SW;
            3'd3:    return OP_LDW;
            3'd4:    return OP_SDW;
            default: return OP_NONE;
        endcase
    endfunction

    function automatic logic is_store(input mem_op_t op);
        return (op == OP_SW) || (op == OP_SDW);
    endfunction

    function automatic logic is_double(input mem_op_t op);
        return (op == OP_LDW) || (op == OP_SDW);
    endfunction

endpackage

// File: rtl/x_mem_rsp.sv
// Read-response side: holds the tag of the last read grant, assembles
// double-word loads and registers the writeback result.
module x_mem_rsp
    import x_mem_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  rd_tag_t         issue_tag_i,
    input  logic            flush_i,
    input  logic            rvalid_i,
    input  logic [DW-1:0]   rdata_i,
    output logic            wb_valid_o,
    output logic [4:0]      wb_rd_o,
    output logic [2*DW-1:0] wb_data_o
);

    rd_tag_t         tag_reg;
    logic [DW-1:0]   buf_lo_reg;
    logic            take;

    // A flush during the response cycle kills the op that owns this tag.
    assign take = rvalid_i && tag_reg.valid && !flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_reg    <= '0;
            buf_lo_reg <= '0;
            wb_valid_o <= 1'b0;
            wb_rd_o    <= '0;
            wb_data_o  <= '0;
        end else begin
            tag_reg    <= issue_tag_i;
            wb_valid_o <= 1'b0;
            if (take) begin
                if (!tag_reg.half) begin
                    buf_lo_reg <= rdata_i;
                end
                if (tag_reg.last) begin
                    wb_valid_o <= 1'b1;
                    wb_rd_o    <= tag_reg.rd;
                    wb_data_o  <= tag_reg.dbl ? {rdata_i, buf_lo_reg}
                                              : {{DW{1'b0}}, rdata_i};
                end
            end
        end
    end

endmodule

// File: rtl/x_mem_seq.sv
// Execute-stage memory sequencer: drives the data-memory port for LW/SW/LDW/SDW,
// splitting double-word ops into two word accesses and stalling decode meanwhile.
module x_mem_seq
    import x_mem_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            x_op_valid_i,
    input  logic [2:0]      x_op_i,
    input  logic [AW-1:0]   x_addr_i,
    input  logic [2*DW-1:0] x_wdata_i,
    input  logic [4:0]      x_rd_i,
    input  logic            x_flush_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [AW-1:0]   dmem_addr_o,
    output logic [DW-1:0]   dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [DW-1:0]   dmem_rdata_i,
    output logic            x_stall_d_o,
    output logic            wb_valid_o,
    output logic [4:0]      wb_rd_o,
    output logic [2*DW-1:0] wb_data_o
);

    localparam int WORD_BYTES = DW / 8;

    state_t          state_reg, state_next;
    mem_op_t         op_reg;
    logic [AW-1:0]   addr_reg;
    logic [2*DW-1:0] wdata_reg;
    logic [4:0]      rd_reg;

    mem_op_t         in_op;
    mem_op_t         cur_op;
    logic            new_op;
    logic            req;
    logic            we;
    logic            half;
    logic            last_access;
    logic            grant;
    logic [AW-1:0]   req_addr;
    logic [DW-1:0]   req_wdata;
    logic [4:0]      req_rd;
    rd_tag_t         issue_tag;

    assign in_op  = x_op_valid_i ? decode_op(x_op_i) : OP_NONE;
    assign new_op = (in_op != OP_NONE) && !x_flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (new_op) begin
                    if (!dmem_gnt_i) begin
                        state_next = ST_PEND0;
                    end else if (is_double(in_op)) begin
                        state_next = ST_PEND1;
                    end
                end
            end
            ST_PEND0: begin
                if (x_flush_i) begin
                    state_next = ST_IDLE;
                end else if (dmem_gnt_i) begin
                    state_next = is_double(op_reg) ? ST_PEND1 : ST_IDLE;
                end
            end
            ST_PEND1: begin
                if (x_flush_i || dmem_gnt_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // In IDLE the request comes straight from the execute stage so a granted
    // single access costs no stall; afterwards only the latched copy is used.
    always_comb begin
        cur_op      = op_reg;
        req         = 1'b0;
        we          = 1'b0;
        half        = 1'b0;
        last_access = 1'b0;
        req_addr    = addr_reg;
        req_wdata   = wdata_reg[DW-1:0];
        req_rd      = rd_reg;
        unique case (state_reg)
            ST_IDLE: begin
                cur_op      = in_op;
                req         = new_op;
                req_addr    = x_addr_i;
                req_wdata   = x_wdata_i[DW-1:0];
                req_rd      = x_rd_i;
                last_access = !is_double(in_op);
            end
            ST_PEND0: begin
                req         = !x_flush_i;
                last_access = !is_double(op_reg);
            end
            ST_PEND1: begin
                req         = !x_flush_i;
                req_addr    = addr_reg + AW'(WORD_BYTES);
                req_wdata   = wdata_reg[2*DW-1:DW];
                half        = 1'b1;
                last_access = 1'b1;
            end
            default: ;
        endcase
        we = req && is_store(cur_op);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_reg    <= OP_NONE;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rd_reg    <= '0;
        end else if (state_reg == ST_IDLE) begin
            op_reg    <= in_op;
            addr_reg  <= x_addr_i;
            wdata_reg <= x_wdata_i;
            rd_reg    <= x_rd_i;
        end
    end

    assign grant = req && dmem_gnt_i;

    always_comb begin
        issue_tag       = '0;
        issue_tag.valid = grant && !we;
        issue_tag.half  = half;
        issue_tag.last  = last_access;
        issue_tag.dbl   = is_double(cur_op);
        issue_tag.rd    = req_rd;
    end

    assign dmem_req_o   = req;
    assign dmem_we_o    = we;
    assign dmem_addr_o  = req_addr;
    assign dmem_wdata_o = req_wdata;
    assign x_stall_d_o  = req && !(dmem_gnt_i && last_access);

    x_mem_rsp #(
        .DW (DW)
    ) u_rsp (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .issue_tag_i (issue_tag),
        .flush_i     (x_flush_i),
        .rvalid_i    (dmem_rvalid_i),
        .rdata_i     (dmem_rdata_i),
        .wb_valid_o  (wb_valid_o),
        .wb_rd_o     (wb_rd_o),
        .wb_data_o   (wb_data_o)
    );

endmodule

// File: tb/tb_x_mem_seq.sv
// Bench for x_mem_seq: transaction-level memory model plus random and directed op streams.
module tb_x_mem_seq;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          op_valid = 1'b0;
    logic [2:0]    x_op = 3'd0;
    logic [31:0]   x_addr = '0;
    logic [63:0]   x_wdata = '0;
    logic [4:0]    x_rd = '0;
    logic          flush = 1'b0;
    logic          gnt = 1'b0;
    logic          rvalid = 1'b0;
    logic [31:0]   rdata = '0;
    logic          dmem_req, dmem_we, stall, wb_valid;
    logic [31:0]   dmem_addr, dmem_wdata;
    logic [4:0]    wb_rd;
    logic [63:0]   wb_data;

    always #5 clk = ~clk;

    x_mem_seq #(.AW(AW), .DW(DW)) dut (
        .clk_i(clk), .rst_i(rst),
        .x_op_valid_i(op_valid), .x_op_i(x_op), .x_addr_i(x_addr),
        .x_wdata_i(x_wdata), .x_rd_i(x_rd), .x_flush_i(flush),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
        .dmem_wdata_o(dmem_wdata), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid),
        .dmem_rdata_i(rdata), .x_stall_d_o(stall),
        .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data)
    );

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [63:0] data;
    } wb_exp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] mem [logic [31:0]];
    wb_exp_t     wbq [$];
    logic        rd_pend = 1'b0;
    logic [31:0] rd_pend_addr = '0;
    logic        s_req, s_we, s_stall, s_wbv;
    logic [31:0] s_addr, s_wdata;
    logic [4:0]  s_wbrd;
    logic [63:0] s_wbdata;
    int          s_cyc;
    logic        prev_rg = 1'b0;

    // Memory only answers reads it granted one cycle earlier.
    always @(posedge clk) begin
        if (!rst && rvalid) begin
            assert (prev_rg) else $error("rvalid driven with no read grant in the previous cycle");
        end
        prev_rg <= !rst && dmem_req && gnt && !dmem_we;
    end

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    // One clock: sample outputs mid-cycle, act as memory, then advance.
    task automatic drive_cycle();
        @(negedge clk);
        s_req = dmem_req; s_we = dmem_we; s_addr = dmem_addr; s_wdata = dmem_wdata;
        s_stall = stall; s_wbv = wb_valid; s_wbrd = wb_rd; s_wbdata = wb_data; s_cyc = cyc;
        if (wbq.size() > 0 && wbq[0].cyc == cyc) begin
            checks++;
            if (wb_valid !== 1'b1 || wb_rd !== wbq[0].rd || wb_data !== wbq[0].data) begin
                errors++;
                $display("FAIL wb cyc=%0d got v=%b rd=%0d data=%h want rd=%0d data=%h",
                         cyc, wb_valid, wb_rd, wb_data, wbq[0].rd, wbq[0].data);
            end
            void'(wbq.pop_front());
        end else if (wb_valid !== 1'b0) begin
            checks++; errors++;
            $display("FAIL wb_unexpected cyc=%0d got v=%b rd=%0d data=%h want v=0", cyc, wb_valid, wb_rd, wb_data);
        end
        rd_pend = !rst && s_req && gnt && !s_we;
        rd_pend_addr = s_addr;
        if (!rst && s_req && gnt && s_we) mem[s_addr] = s_wdata;
        @(posedge clk);
        #1;
        cyc++;
        rvalid = rd_pend;
        rdata  = rd_pend ? mem_rd(rd_pend_addr) : $urandom;
    endtask

    task automatic idle_cycles(input int n);
        op_valid = 1'b0; x_op = 3'd0; flush = 1'b0;
        for (int i = 0; i < n; i++) begin
            gnt = 1'($urandom_range(0, 1));
            drive_cycle();
            checks++;
            if (s_req !== 1'b0 || s_stall !== 1'b0) begin
                errors++;
                $display("FAIL idle cyc=%0d got req=%b stall=%b want 0/0", s_cyc, s_req, s_stall);
            end
        end
    endtask

    // Issues one op and holds it until the pipeline would advance (stall low).
    task automatic do_op(input logic v, input logic [2:0] opc, input logic [31:0] a,
                         input logic [63:0] wd, input logic [4:0] r,
                         input int deny_n, input int deny_pct, input string name);
        logic [31:0] ea [2];
        logic [31:0] ew [2];
        logic [63:0] exp_data;
        logic        st, ld, g, exp_stall;
        int          code, n, idx, den, last_g;
        wb_exp_t     e;
        code = v ? int'(opc) : 0;
        n  = (code == 3 || code == 4) ? 2 : (code == 1 || code == 2) ? 1 : 0;
        st = (code == 2 || code == 4);
        ld = (code == 1 || code == 3);
        ea[0] = a; ea[1] = a + 32'd4;
        ew[0] = wd[31:0]; ew[1] = wd[63:32];
        exp_data = (code == 3) ? {mem_rd(a + 32'd4), mem_rd(a)} : {32'h0, mem_rd(a)};
        idx = 0; den = 0; last_g = 0;
        op_valid = v; x_op = opc; x_addr = a; x_wdata = wd; x_rd = r; flush = 1'b0;
        if (n == 0) begin
            gnt = 1'($urandom_range(0, 1));
            drive_cycle();
            checks++;
            if (s_req !== 1'b0 || s_stall !== 1'b0) begin
                errors++;
                $display("FAIL %s_noop cyc=%0d got req=%b stall=%b want 0/0", name, s_cyc, s_req, s_stall);
            end
        end
        for (int k = 0; k < 64 && idx < n; k++) begin
            g = (den < deny_n) ? 1'b0 : ($urandom_range(0, 99) >= deny_pct);
            gnt = g;
            drive_cycle();
            exp_stall = !(g && idx == n - 1);
            checks++;
            if (s_req !== 1'b1 || s_we !== st || s_addr !== ea[idx] ||
                (st && s_wdata !== ew[idx]) || s_stall !== exp_stall) begin
                errors++;
                $display("FAIL %s_req cyc=%0d got req=%b we=%b addr=%h wd=%h stall=%b want req=1 we=%b addr=%h wd=%h stall=%b",
                         name, s_cyc, s_req, s_we, s_addr, s_wdata, s_stall, st, ea[idx], ew[idx], exp_stall);
            end
            if (g) begin idx++; last_g = s_cyc; end else den++;
            // Once latched, the execute-stage inputs must no longer matter.
            op_valid = 1'($urandom_range(0, 1)); x_op = 3'($urandom_range(0, 7));
            x_addr = $urandom; x_wdata = {$urandom, $urandom}; x_rd = 5'($urandom);
        end
        if (n > 0 && idx < n) begin
            checks++; errors++;
            $display("FAIL %s_timeout accesses=%0d want %0d", name, idx, n);
        end
        if (ld && idx == n) begin
            e.cyc = last_g + 2; e.rd = r; e.data = exp_data;
            wbq.push_back(e);
        end
        $display("op %s v=%b code=%0d addr=%h rd=%0d denials=%0d", name, v, opc, a, r, den);
        op_valid = 1'b0; x_op = 3'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1; op_valid = 1'b0; gnt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_cycle();
            checks++;
            if (s_req !== 1'b0 || s_stall !== 1'b0 || s_wbv !== 1'b0 || s_wbrd !== 5'd0 || s_wbdata !== 64'd0) begin
                errors++;
                $display("FAIL reset got req=%b stall=%b wbv=%b rd=%0d data=%h want all 0",
                         s_req, s_stall, s_wbv, s_wbrd, s_wbdata);
            end
        end
        rst = 1'b0;
        $display("reset released at cyc=%0d", cyc);
    endtask

    task automatic test_lw();
        mem[32'h100] = 32'hDEAD_BEEF;
        do_op(1'b1, 3'd1, 32'h100, 64'h0, 5'd7, 0, 0, "lw");
        idle_cycles(3);
    endtask

    task automatic test_ldw();
        mem[32'h200] = 32'hA0A0_0001; mem[32'h204] = 32'hB0B0_0002;
        do_op(1'b1, 3'd3, 32'h200, 64'h0, 5'd12, 0, 0, "ldw");
        idle_cycles(3);
    endtask

    task automatic test_sdw_wrap();
        do_op(1'b1, 3'd4, 32'hFFFF_FFFC, 64'h1111_2222_3333_4444, 5'd0, 0, 0, "sdw_wrap");
        idle_cycles(2);
        do_op(1'b1, 3'd3, 32'hFFFF_FFFC, 64'h0, 5'd9, 0, 0, "ldw_wrap");
        idle_cycles(3);
    endtask

    task automatic test_lw_wait();
        do_op(1'b1, 3'd1, 32'h180, 64'h0, 5'd21, 3, 0, "lw_wait");
        idle_cycles(3);
    endtask

    task automatic test_flush_pend1();
        mem[32'h300] = 32'hCAFE_0001;
        op_valid = 1'b1; x_op = 3'd3; x_addr = 32'h300; x_rd = 5'd3; flush = 1'b0; gnt = 1'b1;
        drive_cycle();
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h300 || s_stall !== 1'b1) begin
            errors++;
            $display("FAIL flush_w0 got req=%b addr=%h stall=%b want 1/00000300/1", s_req, s_addr, s_stall);
        end
        flush = 1'b1;
        drive_cycle();
        checks++;
        if (s_req !== 1'b0 || s_stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_pend1 got req=%b stall=%b want 0/0", s_req, s_stall);
        end
        flush = 1'b0;
        idle_cycles(3);
        op_valid = 1'b1; x_op = 3'd1; x_addr = 32'h304; flush = 1'b1; gnt = 1'b1;
        drive_cycle();
        checks++;
        if (s_req !== 1'b0 || s_stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle got req=%b stall=%b want 0/0", s_req, s_stall);
        end
        flush = 1'b0;
        do_op(1'b1, 3'd1, 32'h300, 64'h0, 5'd4, 0, 0, "lw_after_flush");
        idle_cycles(3);
        $display("flush scenario done at cyc=%0d", cyc);
    endtask

    task automatic test_reset_mid();
        do_op(1'b1, 3'd1, 32'h500, 64'h0, 5'd11, 0, 0, "lw_pre_rst");
        idle_cycles(3);
        op_valid = 1'b1; x_op = 3'd3; x_addr = 32'h400; x_rd = 5'd5; gnt = 1'b1;
        drive_cycle();
        gnt = 1'b0;
        drive_cycle();
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h404 || s_stall !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pend1 got req=%b addr=%h stall=%b want 1/00000404/1", s_req, s_addr, s_stall);
        end
        op_valid = 1'b0; x_op = 3'd0;
        test_reset();
        do_op(1'b1, 3'd1, 32'h500, 64'h0, 5'd13, 0, 0, "lw_post_rst");
        idle_cycles(3);
    endtask

    task automatic test_back_to_back();
        do_op(1'b1, 3'd1, 32'h600, 64'h0, 5'd1, 0, 0, "b2b_lw");
        do_op(1'b1, 3'd3, 32'h608, 64'h0, 5'd2, 0, 0, "b2b_ldw");
        do_op(1'b1, 3'd2, 32'h600, {32'h0, 32'h1234_5678}, 5'd0, 0, 0, "b2b_sw");
        do_op(1'b1, 3'd1, 32'h600, 64'h0, 5'd3, 0, 0, "b2b_lw2");
        idle_cycles(3);
    endtask

    task automatic test_random();
        logic        v;
        logic [2:0]  o;
        logic [31:0] a;
        for (int i = 0; i < 80; i++) begin
            v = ($urandom_range(0, 9) != 0);
            o = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(1, 4)) : 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : 32'h1000 + 32'(4 * $urandom_range(0, 15));
            do_op(v, o, a, {$urandom, $urandom}, 5'($urandom_range(1, 31)),
                  $urandom_range(0, 2), 30, "rnd");
            if ($urandom_range(0, 4) == 0) idle_cycles(1);
        end
        idle_cycles(4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lw();
        test_ldw();
        test_sdw_wrap();
        test_lw_wait();
        test_flush_pend1();
        test_reset_mid();
        test_back_to_back();
        test_random();
        checks++;
        if (wbq.size() != 0) begin
            errors++;
            $display("FAIL wb_missing got %0d outstanding want 0", wbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
